// File: rtl/inst_seq_checker.sv
// Instruction sequence checker.
// Holds a small program buffer of instruction words, offers them one at a
// time to a CPU over a valid/ready handshake, and optionally checks the
// register writeback each instruction produces against an expected value.
// Supports run-once, single-step and continuous-loop execution, with
// saturating pass/fail/loop counters and first-failure capture.
module inst_seq_checker #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic            start,
    input  logic            step,
    input  logic            abort,
    input  logic [AW:0]     prog_len,
    input  logic            load_we,
    input  logic [AW-1:0]   load_addr,
    input  logic [XLEN-1:0] load_inst,
    input  logic            load_chk,
    input  logic [4:0]      load_rd,
    input  logic [XLEN-1:0] load_exp,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_out,
    input  logic            inst_ready,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   pass_cnt,
    output logic [CW-1:0]   fail_cnt,
    output logic [CW-1:0]   loop_cnt,
    output logic            timeout_flag,
    output logic [AW-1:0]   first_fail_idx,
    output logic            fail_seen
);

    // Entry layout: {inst, chk, rd, exp}
    localparam int EW = 2 * XLEN + 6;
    // Wait counter only needs to reach TIMEOUT-1 before the timeout fires.
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_WB   = 3'd2,
        STEP_HOLD = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    state_t          adv_target;

    logic [EW-1:0]   buf_mem [DEPTH];
    logic [EW-1:0]   cur_entry;
    logic [XLEN-1:0] cur_inst;
    logic            cur_chk;
    logic [4:0]      cur_rd;
    logic [XLEN-1:0] cur_exp;

    logic [AW-1:0]   idx_reg;
    logic [WW-1:0]   wait_reg;
    logic [CW-1:0]   pass_reg;
    logic [CW-1:0]   fail_reg;
    logic [CW-1:0]   loop_reg;
    logic            tflag_reg;
    logic            fseen_reg;
    logic [AW-1:0]   ffi_reg;

    logic            idle_like;
    logic            start_go;
    logic            hs;
    logic            wb_hit;
    logic            tmo;
    logic            adv;
    logic            is_last;
    logic            pass_ev;
    logic            fail_ev;
    logic [AW:0]     last_idx;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    // The current entry is read combinationally so a new word can be
    // offered in the same cycle idx changes, giving bubble-free issue.
    assign cur_entry = buf_mem[idx_reg];
    assign cur_inst  = cur_entry[EW-1 -: XLEN];
    assign cur_chk   = cur_entry[XLEN+5];
    assign cur_rd    = cur_entry[XLEN+4 -: 5];
    assign cur_exp   = cur_entry[XLEN-1:0];

    // Event decode; abort masks every event so nothing else moves.
    assign idle_like = (state_reg == IDLE) || (state_reg == DONE);
    assign start_go  = start && idle_like && !abort;
    assign hs        = (state_reg == ISSUE) && inst_ready && !abort;
    assign wb_hit    = (state_reg == WAIT_WB) && wb_valid && (wb_rd == cur_rd) && !abort;
    assign tmo       = (state_reg == WAIT_WB) && !wb_hit && !abort
                       && (wait_reg == WW'(TIMEOUT - 1));
    assign adv       = (hs && !cur_chk) || wb_hit || tmo;
    assign pass_ev   = wb_hit && (wb_data == cur_exp);
    assign fail_ev   = (wb_hit && (wb_data != cur_exp)) || tmo;
    assign last_idx  = prog_len - (AW+1)'(1);
    assign is_last   = ({1'b0, idx_reg} == last_idx);

    // Program buffer write port, only open while no program is running.
    always_ff @(posedge clk) begin
        if (load_we && idle_like) begin
            buf_mem[load_addr] <= {load_inst, load_chk, load_rd, load_exp};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; mode is sampled at the advancing edge.
    always_comb begin
        state_next = state_reg;
        if (is_last) begin
            adv_target = (mode == 2'b10) ? ISSUE : DONE;
        end else begin
            adv_target = (mode == 2'b01) ? STEP_HOLD : ISSUE;
        end
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_next = (prog_len == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        state_next = cur_chk ? WAIT_WB : adv_target;
                    end
                end
                WAIT_WB: begin
                    if (wb_hit || tmo) begin
                        state_next = adv_target;
                    end
                end
                STEP_HOLD: begin
                    if (step) begin
                        state_next = ISSUE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        inst_valid = (state_reg == ISSUE);
        busy       = (state_reg == ISSUE) || (state_reg == WAIT_WB)
                     || (state_reg == STEP_HOLD);
        done       = (state_reg == DONE);
        inst_out   = cur_inst;
    end

    // Program index, wait counter, result counters and failure capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg   <= '0;
            wait_reg  <= '0;
            pass_reg  <= '0;
            fail_reg  <= '0;
            loop_reg  <= '0;
            tflag_reg <= 1'b0;
            fseen_reg <= 1'b0;
            ffi_reg   <= '0;
        end else if (start_go) begin
            idx_reg   <= '0;
            wait_reg  <= '0;
            pass_reg  <= '0;
            fail_reg  <= '0;
            loop_reg  <= '0;
            tflag_reg <= 1'b0;
            fseen_reg <= 1'b0;
            ffi_reg   <= '0;
        end else begin
            if (hs && cur_chk) begin
                wait_reg <= '0;
            end else if (state_reg == WAIT_WB && !abort) begin
                wait_reg <= wait_reg + WW'(1);
            end
            if (pass_ev) begin
                pass_reg <= sat_inc(pass_reg);
            end
            if (fail_ev) begin
                fail_reg <= sat_inc(fail_reg);
                if (!fseen_reg) begin
                    fseen_reg <= 1'b1;
                    ffi_reg   <= idx_reg;
                end
            end
            if (tmo) begin
                tflag_reg <= 1'b1;
            end
            if (adv) begin
                if (is_last) begin
                    idx_reg <= '0;
                    if (mode == 2'b10) begin
                        loop_reg <= sat_inc(loop_reg);
                    end
                end else begin
                    idx_reg <= idx_reg + AW'(1);
                end
            end
        end
    end

    assign pass_cnt       = pass_reg;
    assign fail_cnt       = fail_reg;
    assign loop_cnt       = loop_reg;
    assign timeout_flag   = tflag_reg;
    assign fail_seen      = fseen_reg;
    assign first_fail_idx = ffi_reg;

endmodule

// File: doc/inst_seq_checker.md
INST_SEQ_CHECKER -- requirements
Module: inst_seq_checker

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning instruction/data width.
REQ-002 The module SHALL have parameter DEPTH, default 16, meaning program-buffer entries (power of two); AW = log2(DEPTH).
REQ-003 The module SHALL have parameter TIMEOUT, default 64, meaning max cycles waited for a writeback.
REQ-004 The module SHALL have parameter CW, default 16, meaning pass/fail/loop counter width.
REQ-005 The module SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  2  00 run-once, 01 single-step, 10 loop, 11 run-once
- start  in  1  begin program, one-cycle pulse
- step  in  1  release next instruction in single-step
- abort  in  1  return to IDLE
- prog_len  in  AW+1  number of entries to execute (0..DEPTH)
- load_we  in  1  program-buffer write strobe
- load_addr  in  AW  entry index
- load_inst  in  XLEN  instruction word
- load_chk  in  1  entry expects a writeback check
- load_rd  in  5  expected destination register
- load_exp  in  XLEN  expected writeback value
- inst_valid  out  1  instruction offered to CPU
- inst_out  out  XLEN  instruction word
- inst_ready  in  1  CPU accepts instruction
- wb_valid  in  1  CPU register writeback strobe
- wb_rd  in  5  writeback register index
- wb_data  in  XLEN  writeback value
- busy  out  1  state not IDLE/DONE
- done  out  1  program completed
- pass_cnt  out  CW  matched checks
- fail_cnt  out  CW  mismatches plus timeouts
- loop_cnt  out  CW  completed loop passes
- timeout_flag  out  1  sticky, any wait timed out
- first_fail_idx  out  AW  entry index of first failure
- fail_seen  out  1  sticky, first_fail_idx valid

Function
REQ-006 States SHALL be IDLE, ISSUE, WAIT_WB, STEP_HOLD, DONE.
REQ-007 load_we SHALL write {inst, chk, rd, exp} to entry load_addr only in IDLE or DONE; ignored otherwise.
REQ-008 start in IDLE/DONE with prog_len>0 SHALL clear pass_cnt, fail_cnt, loop_cnt, timeout_flag, fail_seen, first_fail_idx, done; set idx=0; enter ISSUE next cycle.
REQ-009 start with prog_len=0 SHALL clear the same registers and enter DONE (done=1); start in any other state SHALL be ignored.
REQ-010 In ISSUE, inst_valid SHALL be 1 and inst_out = entry[idx].inst, held stable until inst_valid&inst_ready; inst_valid SHALL be 0 in every other state.
REQ-011 Handshake on an unchecked entry SHALL advance (REQ-014) at the same edge; run modes give back-to-back issue with no bubble.
REQ-012 Handshake on a checked entry SHALL enter WAIT_WB, clear the wait counter; wb_valid coincident with the handshake cycle SHALL be ignored.
REQ-013 In WAIT_WB, wb_valid with wb_rd==entry.rd SHALL compare wb_data to entry.exp: equal -> pass_cnt+1, else fail_cnt+1; then advance. wb_valid with other wb_rd SHALL be ignored. Wait counter reaching TIMEOUT SHALL fail_cnt+1, set timeout_flag, advance.
REQ-015 On each failure with fail_seen=0, first_fail_idx SHALL take idx and fail_seen SHALL set.
REQ-014 Advance: if idx==prog_len-1 then mode=10 -> idx=0, loop_cnt+1, ISSUE; else DONE, done=1. Otherwise idx+1 and mode=01 -> STEP_HOLD, else ISSUE. mode SHALL be sampled at the advance edge.
REQ-016 STEP_HOLD SHALL move to ISSUE on the first cycle step=1.
REQ-017 All counters SHALL saturate at 2^CW-1.
REQ-018 abort SHALL take priority over all events; from any state enter IDLE next edge, inst_valid=0, counters and flags retained, done=0.
REQ-019 busy SHALL be 1 in ISSUE, WAIT_WB, STEP_HOLD; done SHALL stay 1 in DONE until start or abort.

Reset
REQ-020 rst=0 SHALL asynchronously force IDLE, idx=0, inst_valid=0, busy=0, done=0, all counters 0, timeout_flag=0, fail_seen=0, first_fail_idx=0; buffer contents undefined; mid-operation reset drops the in-flight instruction.

Verification
REQ-021 Load 2 unchecked entries 0x00100093, 0x00200113, prog_len=2, mode=00, inst_ready=1, start -> inst_valid 2 consecutive cycles with those words, then done=1, pass_cnt=0.
REQ-022 Entry chk, rd=1, exp=1; wb_valid, wb_rd=1, wb_data=1 two cycles after handshake -> pass_cnt=1, fail_cnt=0, done=1.
REQ-023 Entry chk, rd=2, exp=5; wb_data=4 -> fail_cnt=1, fail_seen=1, first_fail_idx=0; separately, no writeback -> after 64 cycles fail_cnt=1, timeout_flag=1.
REQ-024 mode=01, 3 entries -> second inst_valid only after step pulse; mode=10, prog_len=2 -> after 6 handshakes loop_cnt=3, done=0.
REQ-025 inst_ready=0 for 5 cycles -> inst_out stable; abort during WAIT_WB -> IDLE next edge, counters unchanged; rst=0 mid-run -> all outputs at reset values immediately.
